ppd_commutator: RTL

PPD_COMMUTATOR -- requirements
Module: ppd_commutator

---
 rtl/ppd_commutator_if.sv | 22 ++
 rtl/ppd_commutator.sv | 86 ++++++++
 2 files changed

// File: rtl/ppd_commutator_if.sv
// Sample/block stream bundle between upstream source, the commutator and the mul_add datapath.
interface ppd_commutator_if #(
    parameter int unsigned gp_decimation_factor = 4,
    parameter int unsigned gp_data_width        = 8
);
    logic                                          i_valid;
    logic [gp_data_width-1:0]                      i_data;
    logic                                          o_ready;
    logic [gp_decimation_factor*gp_data_width-1:0] o_data;
    logic                                          o_valid;
    logic                                          i_ready;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_data, o_valid
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_data, o_valid
    );
endinterface

// File: rtl/ppd_commutator.sv
// Polyphase decimator input commutator: deals D consecutive samples into lanes 0..D-1
// and hands the completed block to the datapath through a single output register.
module ppd_commutator #(
    parameter int unsigned gp_decimation_factor = 4,
    parameter int unsigned gp_data_width        = 8
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_ena,
    input  logic                                    i_sync,
    output logic [$clog2(gp_decimation_factor)-1:0] o_phase,
    ppd_commutator_if.slave                         bus
);
    localparam int unsigned D  = gp_decimation_factor;
    localparam int unsigned W  = gp_data_width;
    localparam int unsigned PW = $clog2(D);
    localparam logic [PW-1:0] LAST = PW'(D - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d, phase_eff;
    logic [W-1:0]   fill_q [D];
    logic [W-1:0]   fill_d [D];
    logic [D*W-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           run, stall, accept, load, consume;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = i_ena ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = i_ena ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The last lane may only be accepted if the output register can take the block now.
    assign run         = (state_d == ST_RUN);
    assign stall       = (phase_q == LAST) && valid_q && !bus.i_ready;
    assign bus.o_ready = run && !i_rst && !stall;
    assign accept      = bus.i_valid && bus.o_ready;
    assign phase_eff   = i_sync ? '0 : phase_q;
    assign load        = accept && (phase_eff == LAST);
    assign consume     = valid_q && bus.i_ready;

    always_comb begin
        fill_d  = fill_q;
        phase_d = phase_eff;
        data_d  = data_q;
        valid_d = valid_q && !consume;
        if (i_sync) begin
            for (int unsigned i = 0; i < D; i++) fill_d[i] = '0;
        end
        if (accept) begin
            fill_d[phase_eff] = bus.i_data;
            phase_d           = load ? '0 : phase_eff + 1'b1;
        end
        if (load) begin
            for (int unsigned p = 0; p < D - 1; p++) data_d[p*W +: W] = fill_q[p];
            data_d[(D-1)*W +: W] = bus.i_data;
            valid_d              = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < D; i++) fill_q[i] <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            for (int unsigned i = 0; i < D; i++) fill_q[i] <= fill_d[i];
        end
    end

    assign o_phase     = phase_q;
    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
endmodule
